// File: rtl/button_debouncer_if.sv
// button_debouncer_if
// Groups the per-button signals of the debouncer into one bundle.
//   i_btn     : raw, asynchronous, bouncing button levels
//   i_clr     : per-bit clear mask for o_sticky
//   o_btn     : debounced button levels
//   o_press   : one-cycle pulse on an accepted 0->1 transition
//   o_release : one-cycle pulse on an accepted 1->0 transition
//   o_sticky  : latched press events awaiting clear
//   o_int     : OR of all o_sticky bits
// The master modport drives buttons/clears; the slave modport is the debouncer.
interface button_debouncer_if #(
    parameter int NBTNS = 8
);
    logic [NBTNS-1:0] i_btn;
    logic [NBTNS-1:0] i_clr;
    logic [NBTNS-1:0] o_btn;
    logic [NBTNS-1:0] o_press;
    logic [NBTNS-1:0] o_release;
    logic [NBTNS-1:0] o_sticky;
    logic             o_int;

    modport master (
        output i_btn,
        output i_clr,
        input  o_btn,
        input  o_press,
        input  o_release,
        input  o_sticky,
        input  o_int
    );

    modport slave (
        input  i_btn,
        input  i_clr,
        output o_btn,
        output o_press,
        output o_release,
        output o_sticky,
        output o_int
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer
// Debounces NBTNS independent button inputs. Each bit is synchronized through
// two flops, then must disagree with the current debounced level for HOLD
// consecutive cycles before the new level is accepted. Accepted transitions
// produce registered press/release pulses; presses are latched in a sticky
// register until cleared, and o_int flags any pending sticky bit.
//   i_clk   : sole clock, rising edge
//   i_reset : synchronous, active-high reset
//   bus     : button_debouncer_if slave (i_btn, i_clr in; o_btn, o_press,
//             o_release, o_sticky, o_int out)
module button_debouncer #(
    parameter int NBTNS   = 8,
    parameter int HOLD    = 100000,
    parameter int CTRBITS = 17
) (
    input  logic              i_clk,
    input  logic              i_reset,
    button_debouncer_if.slave bus
);

    // Counter value at which the next disagreeing cycle accepts the new level;
    // reaching it is what keeps the counter from ever wrapping.
    localparam logic [CTRBITS-1:0] HOLD_LAST = CTRBITS'(HOLD - 1);

    logic [NBTNS-1:0]   s1;
    logic [NBTNS-1:0]   s2;
    logic [NBTNS-1:0]   btn_q;
    logic [NBTNS-1:0]   press_q;
    logic [NBTNS-1:0]   release_q;
    logic [NBTNS-1:0]   sticky_q;
    logic [NBTNS-1:0]   accept;
    logic [CTRBITS-1:0] ctr [NBTNS];

    // A bit is accepted when it still disagrees and has already disagreed
    // for HOLD-1 previous cycles.
    always_comb begin
        accept = '0;
        for (int k = 0; k < NBTNS; k++) begin
            accept[k] = (s2[k] != btn_q[k]) && (ctr[k] == HOLD_LAST);
        end
    end

    // Synchronizer, stability counters, debounced level, event pulses and
    // sticky press latch. An accepted bit toggles btn_q, so the direction of
    // the transition is simply the synchronized level s2. A press being
    // accepted overrides a clear on the same bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1        <= '0;
            s2        <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            sticky_q  <= '0;
            for (int k = 0; k < NBTNS; k++) begin
                ctr[k] <= '0;
            end
        end else begin
            s1        <= bus.i_btn;
            s2        <= s1;
            btn_q     <= btn_q ^ accept;
            press_q   <= accept & s2;
            release_q <= accept & ~s2;
            sticky_q  <= (sticky_q & ~bus.i_clr) | (accept & s2);
            for (int k = 0; k < NBTNS; k++) begin
                if ((s2[k] == btn_q[k]) || accept[k]) begin
                    ctr[k] <= '0;
                end else begin
                    ctr[k] <= ctr[k] + CTRBITS'(1);
                end
            end
        end
    end

    assign bus.o_btn     = btn_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_sticky  = sticky_q;
    assign bus.o_int     = |sticky_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
// Directed bench for button_debouncer with HOLD=4, NBTNS=8. Inputs change 1ns
// after a rising edge and outputs are sampled at that same point, so after
// driving a new level the debounced output is expected to change on the 6th
// following edge (HOLD+1 edges after the first sampling edge).
module tb_button_debouncer;

    localparam int NBTNS   = 8;
    localparam int HOLD    = 4;
    localparam int CTRBITS = 17;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    button_debouncer_if #(.NBTNS(NBTNS)) bus ();

    button_debouncer #(
        .NBTNS   (NBTNS),
        .HOLD    (HOLD),
        .CTRBITS (CTRBITS)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.i_btn  = '0;
        bus.i_clr  = '0;
        tick();
        tick();
        n_compared++;
        if (bus.o_btn !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_btn: got %h expected %h", bus.o_btn, 8'h00);
        end
        n_compared++;
        if (bus.o_press !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_press: got %h expected %h", bus.o_press, 8'h00);
        end
        n_compared++;
        if (bus.o_release !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release: got %h expected %h", bus.o_release, 8'h00);
        end
        n_compared++;
        if (bus.o_sticky !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_sticky: got %h expected %h", bus.o_sticky, 8'h00);
        end
        n_compared++;
        if (bus.o_int !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_int: got %b expected %b", bus.o_int, 1'b0);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        bus.i_btn = 8'h01;
        for (int i = 0; i < HOLD + 1; i++) begin
            tick();
            n_compared++;
            if (bus.o_btn !== 8'h00 || bus.o_press !== 8'h00) begin
                n_mismatched++;
                $display("[TB] FAIL press_early[%0d]: got btn %h press %h expected 00 00", i, bus.o_btn, bus.o_press);
            end
        end
        tick();
        n_compared++;
        if (bus.o_btn !== 8'h01) begin
            n_mismatched++;
            $display("[TB] FAIL press_btn: got %h expected %h", bus.o_btn, 8'h01);
        end
        n_compared++;
        if (bus.o_press !== 8'h01) begin
            n_mismatched++;
            $display("[TB] FAIL press_pulse: got %h expected %h", bus.o_press, 8'h01);
        end
        n_compared++;
        if (bus.o_sticky !== 8'h01 || bus.o_int !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL press_sticky: got %h/%b expected 01/1", bus.o_sticky, bus.o_int);
        end
        tick();
        n_compared++;
        if (bus.o_press !== 8'h00 || bus.o_btn !== 8'h01) begin
            n_mismatched++;
            $display("[TB] FAIL press_once: got press %h btn %h expected 00 01", bus.o_press, bus.o_btn);
        end
    endtask

    task automatic test_bounce();
        // High runs of 1, 2 and 3 cycles separated by single low cycles.
        logic [8:0] pattern;
        int         press_count;
        int         first_press;
        pattern     = 9'b011101101;
        press_count = 0;
        first_press = -1;
        for (int i = 0; i < 9; i++) begin
            bus.i_btn = {5'b00000, pattern[i], 2'b01};
            tick();
            n_compared++;
            if (bus.o_btn !== 8'h01 || bus.o_press !== 8'h00) begin
                n_mismatched++;
                $display("[TB] FAIL bounce_glitch[%0d]: got btn %h press %h expected 01 00", i, bus.o_btn, bus.o_press);
            end
        end
        bus.i_btn = 8'h05;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.o_press !== 8'h00) begin
                press_count++;
                if (first_press < 0) first_press = i;
                n_compared++;
                if (bus.o_press !== 8'h04) begin
                    n_mismatched++;
                    $display("[TB] FAIL bounce_press_val: got %h expected %h", bus.o_press, 8'h04);
                end
            end
        end
        n_compared++;
        if (press_count !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL bounce_press_count: got %0d expected %0d", press_count, 1);
        end
        n_compared++;
        if (first_press !== HOLD + 2) begin
            n_mismatched++;
            $display("[TB] FAIL bounce_latency: got %0d expected %0d", first_press, HOLD + 2);
        end
        n_compared++;
        if (bus.o_btn !== 8'h05 || bus.o_sticky !== 8'h05) begin
            n_mismatched++;
            $display("[TB] FAIL bounce_state: got btn %h sticky %h expected 05 05", bus.o_btn, bus.o_sticky);
        end
    endtask

    task automatic test_release();
        bus.i_btn = 8'h04;
        for (int i = 0; i < HOLD + 1; i++) begin
            tick();
            n_compared++;
            if (bus.o_release !== 8'h00 || bus.o_btn !== 8'h05) begin
                n_mismatched++;
                $display("[TB] FAIL release_early[%0d]: got rel %h btn %h expected 00 05", i, bus.o_release, bus.o_btn);
            end
        end
        tick();
        n_compared++;
        if (bus.o_release !== 8'h01) begin
            n_mismatched++;
            $display("[TB] FAIL release_pulse: got %h expected %h", bus.o_release, 8'h01);
        end
        n_compared++;
        if (bus.o_btn !== 8'h04 || bus.o_sticky !== 8'h05 || bus.o_press !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL release_state: got btn %h sticky %h press %h expected 04 05 00", bus.o_btn, bus.o_sticky, bus.o_press);
        end
        tick();
        n_compared++;
        if (bus.o_release !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL release_once: got %h expected %h", bus.o_release, 8'h00);
        end
    endtask

    task automatic test_clear_race();
        bus.i_btn = 8'h00;
        bus.i_clr = 8'hFF;
        for (int i = 0; i < 8; i++) tick();
        bus.i_clr = 8'h00;
        n_compared++;
        if (bus.o_btn !== 8'h00 || bus.o_sticky !== 8'h00 || bus.o_int !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL clear_all: got btn %h sticky %h int %b expected 00 00 0", bus.o_btn, bus.o_sticky, bus.o_int);
        end
        bus.i_btn = 8'h01;
        for (int i = 0; i < HOLD + 1; i++) tick();
        // The next edge accepts the press of bit 0 while clear is asserted.
        bus.i_clr = 8'h01;
        tick();
        n_compared++;
        if (bus.o_press !== 8'h01 || bus.o_sticky !== 8'h01 || bus.o_int !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL clear_race: got press %h sticky %h int %b expected 01 01 1", bus.o_press, bus.o_sticky, bus.o_int);
        end
        tick();
        bus.i_clr = 8'h00;
        n_compared++;
        if (bus.o_sticky !== 8'h00 || bus.o_int !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL clear_after: got sticky %h int %b expected 00 0", bus.o_sticky, bus.o_int);
        end
    endtask

    task automatic test_independence();
        bus.i_btn = 8'h00;
        for (int i = 0; i < HOLD + 2; i++) tick();
        bus.i_btn = 8'hA5;
        for (int i = 0; i < HOLD + 1; i++) begin
            tick();
            n_compared++;
            if (bus.o_press !== 8'h00) begin
                n_mismatched++;
                $display("[TB] FAIL indep_early[%0d]: got press %h expected 00", i, bus.o_press);
            end
        end
        tick();
        n_compared++;
        if (bus.o_press !== 8'hA5 || bus.o_btn !== 8'hA5) begin
            n_mismatched++;
            $display("[TB] FAIL indep_press: got press %h btn %h expected a5 a5", bus.o_press, bus.o_btn);
        end
        n_compared++;
        if (bus.o_sticky !== 8'hA5 || bus.o_int !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL indep_sticky: got sticky %h int %b expected a5 1", bus.o_sticky, bus.o_int);
        end
    endtask

    task automatic test_reset_mid_count();
        bus.i_btn = 8'hFF;
        for (int i = 0; i < HOLD; i++) tick();
        reset = 1'b1;
        tick();
        n_compared++;
        if (bus.o_btn !== 8'h00 || bus.o_press !== 8'h00 || bus.o_release !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_pulses: got btn %h press %h rel %h expected 00 00 00", bus.o_btn, bus.o_press, bus.o_release);
        end
        n_compared++;
        if (bus.o_sticky !== 8'h00 || bus.o_int !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_sticky: got sticky %h int %b expected 00 0", bus.o_sticky, bus.o_int);
        end
        reset = 1'b0;
        for (int i = 0; i < HOLD + 1; i++) begin
            tick();
            n_compared++;
            if (bus.o_btn !== 8'h00 || bus.o_press !== 8'h00) begin
                n_mismatched++;
                $display("[TB] FAIL midreset_early[%0d]: got btn %h press %h expected 00 00", i, bus.o_btn, bus.o_press);
            end
        end
        tick();
        n_compared++;
        if (bus.o_btn !== 8'hFF || bus.o_press !== 8'hFF || bus.o_sticky !== 8'hFF) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_press: got btn %h press %h sticky %h expected ff ff ff", bus.o_btn, bus.o_press, bus.o_sticky);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        bus.i_btn    = '0;
        bus.i_clr    = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_clear_race();
        test_independence();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter NBTNS, default 8, number of button/switch inputs.
REQ-002 SHALL have parameter HOLD, default 100000, stable cycles required before accepting a new level; legal range 2 to 2^CTRBITS-1.
REQ-003 SHALL have parameter CTRBITS, default 17, width of each per-button stability counter.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_btn  input  NBTNS  raw, asynchronous, bouncing button levels.
REQ-007 SHALL have port i_clr  input  NBTNS  per-bit clear mask for o_sticky, sampled every cycle.
REQ-008 SHALL have port o_btn  output  NBTNS  debounced button levels, registered.
REQ-009 SHALL have port o_press  output  NBTNS  one-cycle pulse per bit on an accepted 0->1 transition, registered.
REQ-010 SHALL have port o_release  output  NBTNS  one-cycle pulse per bit on an accepted 1->0 transition, registered.
REQ-011 SHALL have port o_sticky  output  NBTNS  latched press events awaiting clear, registered.
REQ-012 SHALL have port o_int  output  1  interrupt, equal to the OR of all o_sticky bits (combinational from o_sticky).

Function
REQ-013 SHALL pass each i_btn bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 SHALL keep one CTRBITS-wide counter per bit; all bits SHALL operate independently.
REQ-015 SHALL, on any cycle where s2[k] == o_btn[k], set counter[k] to 0.
REQ-016 SHALL, on a cycle where s2[k] != o_btn[k] and counter[k] < HOLD-1, increment counter[k] by 1.
REQ-017 SHALL, on a cycle where s2[k] != o_btn[k] and counter[k] == HOLD-1, load o_btn[k] <= s2[k] and set counter[k] to 0.
REQ-018 SHALL never allow counter wrap-around; counter saturates through REQ-017 at HOLD-1.
REQ-019 SHALL produce the resulting latency: with i_btn[k] stable at a new level first sampled at edge 0, o_btn[k] takes the new level after edge HOLD+1.
REQ-020 SHALL discard any glitch shorter than HOLD cycles at s2; one cycle of agreement restarts the count from 0.
REQ-021 SHALL assert o_press[k] for exactly the cycle following the edge where o_btn[k] goes 0->1; otherwise 0.
REQ-022 SHALL assert o_release[k] for exactly the cycle following the edge where o_btn[k] goes 1->0; otherwise 0.
REQ-023 SHALL set o_sticky[k] on the same edge that o_press[k] is asserted.
REQ-024 SHALL clear o_sticky[k] on an edge where i_clr[k] is 1 and no press of bit k is being accepted.
REQ-025 SHALL, on a simultaneous press acceptance and i_clr[k], leave o_sticky[k] set (set wins).
REQ-026 SHALL leave o_sticky unaffected by releases.

Reset
REQ-027 SHALL, on an edge with i_reset high, clear s1, s2, all counters, o_btn, o_press, o_release and o_sticky to 0; o_int is therefore 0.
REQ-028 SHALL treat a button held high through reset as a new press: o_btn goes high HOLD+1 edges after the first post-reset edge, and o_press pulses.
REQ-029 SHALL, on reset mid-count, abandon the partial count with no pulse emitted.

Verification (HOLD=4, NBTNS=8)
REQ-030 SHALL cover clean press: i_btn[0] 0->1 and held, no reset -> o_btn[0]=1 after edge 5, o_press=8'h01 for one cycle, o_sticky=8'h01, o_int=1.
REQ-031 SHALL cover bounce: i_btn[2] toggles with high runs of 1, 2 and 3 cycles, then held high -> no o_btn/o_press change until 4 stable s2 cycles; exactly one o_press[2] pulse.
REQ-032 SHALL cover release: from o_btn=8'h01, drop i_btn[0] -> o_release=8'h01 one cycle after 5 edges; o_sticky unchanged at 8'h01.
REQ-033 SHALL cover clear race: i_clr=8'h01 asserted on the same edge that a press of bit 0 is accepted -> o_sticky[0] stays 1; i_clr=8'h01 next cycle -> o_sticky=0, o_int=0.
REQ-034 SHALL cover independence: i_btn=8'hA5 in one step -> o_press=8'hA5 in a single cycle, o_btn=8'hA5, o_sticky=8'hA5.
REQ-035 SHALL cover reset mid-count: i_reset pulsed after 2 counting cycles with i_btn held high -> all outputs 0 during reset, then o_btn=8'hFF and o_press=8'hFF 5 edges after reset release.
